// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle EX-stage ALU with valid/ready handshake.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the 1-bit/cycle shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  logic [1:0]         state;
  logic [WIDTH-1:0]   value;
  logic [SHAMT_W-1:0] shamt;
  assign shamt      = src_b[SHAMT_W-1:0];
  assign req_ready  = state == IDLE;
  assign resp_valid = state == DONE;
  always_comb begin
    value = '0;
    case (ALUControl)
      3'b000:  value = src_a + src_b;
      3'b001:  value = src_a - src_b;
      3'b010:  value = src_a & src_b;
      3'b011:  value = src_a | src_b;
      3'b100:  value = src_a ^ src_b;
      3'b101:  value = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
`ifdef ALU_FAST_SHIFT_EN
      3'b110:  value = src_a << shamt;
      default: value = src_a >> shamt;
`else
      // Iterative build only reaches here for shamt==0 shifts.
      default: value = src_a;
`endif
    endcase
  end
`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] count;
  logic               left;
  logic               is_shift;
  assign is_shift = ALUControl[2] & ALUControl[1];
  assign acc_next = left ? acc << 1 : acc >> 1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc    <= '0;
      count  <= '0;
      left   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift && shamt != '0) begin
            acc   <= src_a;
            count <= shamt;
            left  <= ~ALUControl[0];
            state <= SHIFT;
          end else
`endif
          begin
            result <= value;
            zero   <= value == '0;
            state  <= DONE;
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            result <= acc_next;
            zero   <= acc_next == '0;
            state  <= DONE;
          end
        end
`endif
        DONE: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
